rv_hazard_ctrl: RTL and testbench
=================================

RV_HAZARD_CTRL -- requirements
Module: rv_hazard_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2: number of consecutive cycles the front-end flush is held per redirect; legal range 1..15.
REQ-002 SHALL have parameter CNT_BITS, default 16: width of the stall-cycle counter.
REQ-003 SHALL have port i_clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports i_dec_rs1 and i_dec_rs2, input, 5 each: source registers of the instruction in decode.
REQ-006 SHALL have ports i_alu1_rs1 and i_alu1_rs2, input, 5 each: source registers of the instruction in ALU1.
REQ-007 SHALL have ports i_alu1_rd (input, 5), i_alu1_reg_write (input, 1) and i_alu1_load (input, 1): ALU1 destination, its write enable, and "result comes from memory".
REQ-008 SHALL have ports i_alu2_rd (input, 5), i_alu2_reg_write (input, 1), i_wb_rd (input, 5) and i_wb_reg_write (input, 1): later-stage writers.
REQ-009 SHALL have ports i_div_start (input, 1) and i_div_done (input, 1): a multi-cycle op enters execute, and its result is valid.
REQ-010 SHALL have ports i_pc_select (input, 1) and i_trap (input, 1): branch/jump redirect taken, and trap or mret redirect.
REQ-011 SHALL have ports o_stall_fetch, o_stall_dec and o_stall_alu1, output, 1 each: stage hold enables.
REQ-012 SHALL have ports o_flush_dec and o_flush_alu1, output, 1 each: stage register clears.
REQ-013 SHALL have ports o_fwd1_sel and o_fwd2_sel, output, 2 each: operand source; 00 = register file, 01 = ALU2 result, 10 = WB result.
REQ-014 SHALL have ports o_div_abort (output, 1), o_busy (output, 1) and o_stall_cnt (output, CNT_BITS): abort pulse to the divider, FSM not in IDLE, and saturating count of stalled cycles.

Function
REQ-015 SHALL implement FSM states IDLE, DIV_WAIT and FLUSH, with a 4-bit flush counter fcnt.
REQ-016 SHALL select o_fwdN_sel combinationally from i_alu1_rsN as follows: 01 if i_alu2_reg_write is set, i_alu2_rd != 0 and i_alu2_rd == rsN; otherwise 10 if the same condition holds for WB; otherwise 00. ALU2 SHALL take priority over WB.
REQ-017 SHALL detect load-use combinationally when state = IDLE, i_alu1_load = 1, i_alu1_reg_write = 1, i_alu1_rd != 0, and i_alu1_rd equals i_dec_rs1 or i_dec_rs2.
REQ-018 On load-use, SHALL assert o_stall_fetch and o_stall_dec, deassert o_stall_alu1, and assert o_flush_alu1 (bubble insertion), all in the same cycle.
REQ-019 In IDLE with i_div_start = 1, SHALL assert all three stalls combinationally that cycle and move to DIV_WAIT.
REQ-020 In DIV_WAIT, SHALL assert all three stalls while i_div_done = 0.
REQ-021 In DIV_WAIT with i_div_done = 1, SHALL release all stalls that same cycle and move to IDLE.
REQ-022 If i_div_start and i_div_done are both 1 in IDLE, SHALL treat the op as single-cycle: no stall, stay in IDLE.
REQ-023 On i_pc_select or i_trap in any state, SHALL assert o_flush_dec and o_flush_alu1 that cycle.
REQ-024 On that event, if FLUSH_CYCLES > 1, SHALL go to FLUSH with fcnt = FLUSH_CYCLES-2; otherwise SHALL go to IDLE.
REQ-025 In FLUSH, SHALL assert both flushes each cycle, decrement fcnt, and return to IDLE after the cycle in which fcnt = 0.
REQ-026 A new i_pc_select or i_trap while in FLUSH SHALL reload fcnt as in REQ-024.
REQ-027 On i_trap while in DIV_WAIT, or on i_trap with i_div_start in IDLE, SHALL pulse o_div_abort for exactly 1 cycle; i_pc_select SHALL NOT abort a divide.
REQ-028 Priority: i_trap > i_pc_select > divide > load-use. Whenever any flush is asserted, all stalls SHALL be 0 and load-use SHALL be suppressed.
REQ-029 o_stall_cnt SHALL increment each cycle o_stall_fetch = 1 and saturate at all-ones.
REQ-030 o_busy SHALL equal (state != IDLE).

Reset
REQ-031 While i_reset = 1 at a clock edge, SHALL force state = IDLE, fcnt = 0 and o_stall_cnt = 0.
REQ-032 Reset SHALL override any event in the same cycle. Mid-DIV_WAIT reset SHALL produce no o_div_abort.
REQ-033 After reset, SHALL hold all stall, flush and abort outputs at 0, o_fwd*_sel at 00, and o_busy at 0 until a qualifying input arrives.

Verification
REQ-034 Load-use: alu1_load = 1, alu1_rd = 5, dec_rs2 = 5 for one cycle -> stall_fetch = stall_dec = flush_alu1 = 1 and stall_alu1 = 0 that cycle; stall_cnt = 1.
REQ-035 Forwarding: alu2_rd = wb_rd = 7 (both writing), alu1_rs1 = 7, alu1_rs2 = 0 -> fwd1_sel = 01, fwd2_sel = 00; with alu2_reg_write = 0 -> fwd1_sel = 10.
REQ-036 Divide: div_start at cycle 0, div_done at cycle 4 -> stalls high in cycles 0-3 and low in cycle 4; o_busy high in cycles 1-4; state IDLE at cycle 5.
REQ-037 Redirect: pc_select for 1 cycle, FLUSH_CYCLES = 2 -> flushes high for exactly 2 cycles; a second pc_select in cycle 1 extends the flush to cycle 2.
REQ-038 Trap during DIV_WAIT -> div_abort = 1 for 1 cycle, flushes = 1, stalls = 0; divider done arriving later is ignored and no stall occurs.
REQ-039 Reset mid-FLUSH -> next cycle flushes = 0, busy = 0, stall_cnt = 0.

Source files
------------

// File: rtl/rv_hazard_ctrl.sv
// rv_hazard_ctrl: pipeline hazard controller for an in-order RISC-V core.
//
// Purpose
//   - Selects operand forwarding sources for the instruction in ALU1.
//   - Detects load-use hazards and inserts a bubble into ALU1.
//   - Holds the pipeline while a multi-cycle divide is in flight.
//   - Flushes decode/ALU1 for FLUSH_CYCLES cycles on a branch/jump/trap redirect.
//   - Aborts an in-flight divide on a trap.
//   - Counts stalled cycles with a saturating counter.
//
// Ports
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_dec_rs1/2               decode-stage source registers
//   i_alu1_rs1/2, i_alu1_rd   ALU1 sources/destination
//   i_alu1_reg_write          ALU1 writes a register
//   i_alu1_load               ALU1 result comes from memory
//   i_alu2_rd/_reg_write      ALU2 writer
//   i_wb_rd/_reg_write        WB writer
//   i_div_start, i_div_done   divide enters execute / divide result valid
//   i_pc_select, i_trap       branch/jump redirect, trap/mret redirect
//   o_stall_fetch/dec/alu1    stage hold enables
//   o_flush_dec/alu1          stage register clears
//   o_fwd1_sel, o_fwd2_sel    00 = regfile, 01 = ALU2 result, 10 = WB result
//   o_div_abort               one-cycle abort to the divider
//   o_busy                    controller is not in IDLE
//   o_stall_cnt               saturating count of cycles with fetch stalled
//   o_dbg_state               current FSM state (0 IDLE, 1 DIV_WAIT, 2 FLUSH)
//
// Handshake note: there is no valid/ready pair here. Every stall/flush/
// forward output is a level that the pipeline samples on the same rising
// edge; o_div_abort is a single-cycle pulse the divider must accept
// unconditionally.
module rv_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_BITS     = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [4:0]          i_dec_rs1,
  input  logic [4:0]          i_dec_rs2,
  input  logic [4:0]          i_alu1_rs1,
  input  logic [4:0]          i_alu1_rs2,
  input  logic [4:0]          i_alu1_rd,
  input  logic                i_alu1_reg_write,
  input  logic                i_alu1_load,
  input  logic [4:0]          i_alu2_rd,
  input  logic                i_alu2_reg_write,
  input  logic [4:0]          i_wb_rd,
  input  logic                i_wb_reg_write,
  input  logic                i_div_start,
  input  logic                i_div_done,
  input  logic                i_pc_select,
  input  logic                i_trap,
  output logic                o_stall_fetch,
  output logic                o_stall_dec,
  output logic                o_stall_alu1,
  output logic                o_flush_dec,
  output logic                o_flush_alu1,
  output logic [1:0]          o_fwd1_sel,
  output logic [1:0]          o_fwd2_sel,
  output logic                o_div_abort,
  output logic                o_busy,
  output logic [CNT_BITS-1:0] o_stall_cnt,
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  // fcnt counts the flush cycles still owed after the current one, minus one:
  // a redirect flushes this cycle plus FLUSH_CYCLES-1 cycles in FLUSH.
  localparam logic [3:0] FCNT_RELOAD = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;
  localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [3:0]          fcnt_q, fcnt_d;
  logic [CNT_BITS-1:0] stall_cnt_q, stall_cnt_d;

  logic redirect;
  logic load_use;

  // Forwarding: ALU2 is the younger producer, so it wins over WB. x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (i_alu2_reg_write && (i_alu2_rd != 5'd0) && (i_alu2_rd == rs)) begin
      return 2'b01;
    end else if (i_wb_reg_write && (i_wb_rd != 5'd0) && (i_wb_rd == rs)) begin
      return 2'b10;
    end
    return 2'b00;
  endfunction

  assign o_fwd1_sel = fwd_sel(i_alu1_rs1);
  assign o_fwd2_sel = fwd_sel(i_alu1_rs2);

  assign redirect = i_trap | i_pc_select;
  assign load_use = i_alu1_load && i_alu1_reg_write && (i_alu1_rd != 5'd0) &&
                    ((i_alu1_rd == i_dec_rs1) || (i_alu1_rd == i_dec_rs2));

  always_comb begin
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    o_stall_fetch = 1'b0;
    o_stall_dec   = 1'b0;
    o_stall_alu1  = 1'b0;
    o_flush_dec   = 1'b0;
    o_flush_alu1  = 1'b0;
    o_div_abort   = 1'b0;

    if (redirect) begin
      // Redirect beats everything; stalls stay low so the flush takes effect.
      o_flush_dec  = 1'b1;
      o_flush_alu1 = 1'b1;
      o_div_abort  = i_trap && ((state_q == DIV_WAIT) || ((state_q == IDLE) && i_div_start));
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        fcnt_d  = FCNT_RELOAD;
      end else begin
        state_d = IDLE;
        fcnt_d  = 4'd0;
      end
    end else begin
      case (state_q)
        FLUSH: begin
          o_flush_dec  = 1'b1;
          o_flush_alu1 = 1'b1;
          if (fcnt_q == 4'd0) begin
            state_d = IDLE;
          end else begin
            fcnt_d = fcnt_q - 4'd1;
          end
        end
        DIV_WAIT: begin
          if (i_div_done) begin
            state_d = IDLE;
          end else begin
            o_stall_fetch = 1'b1;
            o_stall_dec   = 1'b1;
            o_stall_alu1  = 1'b1;
          end
        end
        default: begin
          // start+done together is a single-cycle op: no stall at all.
          if (i_div_start && !i_div_done) begin
            o_stall_fetch = 1'b1;
            o_stall_dec   = 1'b1;
            o_stall_alu1  = 1'b1;
            state_d       = DIV_WAIT;
          end else if (load_use) begin
            // Hold fetch/decode, let ALU1 advance into a bubble.
            o_stall_fetch = 1'b1;
            o_stall_dec   = 1'b1;
            o_flush_alu1  = 1'b1;
          end
        end
      endcase
    end

    // Reset wins over any same-cycle event, including a trap abort.
    if (i_reset) begin
      o_stall_fetch = 1'b0;
      o_stall_dec   = 1'b0;
      o_stall_alu1  = 1'b0;
      o_flush_dec   = 1'b0;
      o_flush_alu1  = 1'b0;
      o_div_abort   = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (o_stall_fetch && (stall_cnt_q != {CNT_BITS{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      fcnt_q      <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_busy      = (state_q != IDLE);
  assign o_stall_cnt = stall_cnt_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_rv_hazard_ctrl.sv
// Testbench for rv_hazard_ctrl: directed vectors, a cycle-level behavioural
// model (remaining-flush count + divide-in-flight flag + stall tally) checked
// every cycle, and literal expectations at key points of each scenario.
module tb_rv_hazard_ctrl;

  localparam int FC       = 2;
  localparam int CB       = 4;
  localparam int CNT_MAX  = (1 << CB) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [4:0] dec_rs1, dec_rs2, alu1_rs1, alu1_rs2, alu1_rd, alu2_rd, wb_rd;
  logic       alu1_reg_write, alu1_load, alu2_reg_write, wb_reg_write;
  logic       div_start, div_done, pc_select, trap;
  logic       stall_fetch, stall_dec, stall_alu1, flush_dec, flush_alu1;
  logic [1:0] fwd1_sel, fwd2_sel, dbg_state;
  logic       div_abort, busy;
  logic [CB-1:0] stall_cnt;

  rv_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_BITS(CB)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_dec_rs1(dec_rs1), .i_dec_rs2(dec_rs2),
    .i_alu1_rs1(alu1_rs1), .i_alu1_rs2(alu1_rs2),
    .i_alu1_rd(alu1_rd), .i_alu1_reg_write(alu1_reg_write), .i_alu1_load(alu1_load),
    .i_alu2_rd(alu2_rd), .i_alu2_reg_write(alu2_reg_write),
    .i_wb_rd(wb_rd), .i_wb_reg_write(wb_reg_write),
    .i_div_start(div_start), .i_div_done(div_done),
    .i_pc_select(pc_select), .i_trap(trap),
    .o_stall_fetch(stall_fetch), .o_stall_dec(stall_dec), .o_stall_alu1(stall_alu1),
    .o_flush_dec(flush_dec), .o_flush_alu1(flush_alu1),
    .o_fwd1_sel(fwd1_sel), .o_fwd2_sel(fwd2_sel),
    .o_div_abort(div_abort), .o_busy(busy), .o_stall_cnt(stall_cnt),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_flush_left: flush cycles still owed after the current cycle.
  // m_in_div:     a divide is outstanding and has not completed.
  int m_flush_left = 0, n_flush_left;
  bit m_in_div = 1'b0, n_in_div;
  int m_cnt = 0;
  bit e_sf, e_sd, e_sa, e_fd, e_fa, e_ab, e_busy, m_idle;

  function automatic int fwd_model(input logic [4:0] rs);
    if (alu2_reg_write && alu2_rd != 0 && alu2_rd == rs) return 1;
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2;
    return 0;
  endfunction

  always @(negedge clk) begin
    e_sf = 0; e_sd = 0; e_sa = 0; e_fd = 0; e_fa = 0; e_ab = 0;
    n_flush_left = m_flush_left;
    n_in_div     = m_in_div;
    m_idle       = !m_in_div && (m_flush_left == 0);
    e_busy       = !m_idle;
    if (rst) begin
      n_flush_left = 0;
      n_in_div     = 0;
    end else if (trap || pc_select) begin
      e_fd = 1; e_fa = 1;
      e_ab = trap && (m_in_div || (m_idle && div_start));
      n_in_div     = 0;
      n_flush_left = FC - 1;
    end else if (m_flush_left > 0) begin
      e_fd = 1; e_fa = 1;
      n_flush_left = m_flush_left - 1;
    end else if (m_in_div) begin
      if (div_done) n_in_div = 0;
      else begin e_sf = 1; e_sd = 1; e_sa = 1; end
    end else if (div_start && !div_done) begin
      e_sf = 1; e_sd = 1; e_sa = 1;
      n_in_div = 1;
    end else if (alu1_load && alu1_reg_write && alu1_rd != 0 &&
                 (alu1_rd == dec_rs1 || alu1_rd == dec_rs2)) begin
      e_sf = 1; e_sd = 1; e_fa = 1;
    end
    if (check_en) begin
      chk("stall_fetch", stall_fetch, e_sf);
      chk("stall_dec",   stall_dec,   e_sd);
      chk("stall_alu1",  stall_alu1,  e_sa);
      chk("flush_dec",   flush_dec,   e_fd);
      chk("flush_alu1",  flush_alu1,  e_fa);
      chk("div_abort",   div_abort,   e_ab);
      chk("busy",        busy,        e_busy);
      chk("stall_cnt",   stall_cnt,   m_cnt);
      chk("fwd1_sel",    fwd1_sel,    fwd_model(alu1_rs1));
      chk("fwd2_sel",    fwd2_sel,    fwd_model(alu1_rs2));
    end
  end

  always @(posedge clk) begin
    if (rst) m_cnt = 0;
    else if (e_sf && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    m_flush_left = n_flush_left;
    m_in_div     = n_in_div;
  end

  // ---------------- driver tasks ----------------
  task automatic clr();
    dec_rs1 = 0; dec_rs2 = 0; alu1_rs1 = 0; alu1_rs2 = 0; alu1_rd = 0;
    alu2_rd = 0; wb_rd = 0; alu1_reg_write = 0; alu1_load = 0;
    alu2_reg_write = 0; wb_reg_write = 0; div_start = 0; div_done = 0;
    pc_select = 0; trap = 0;
  endtask

  // Advance one cycle; inputs change 1 ns after the edge and default to idle.
  task automatic step();
    @(posedge clk);
    #1;
    clr();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    clr();
    rst = 1'b1;
    @(posedge clk); #1;
    check_en = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall_fetch, 0);
    chk("rst_cnt", stall_cnt, 0);
    step();
    rst = 1'b0;
    #1;
    chk("idle_fwd1", fwd1_sel, 0);
    chk("idle_flush", flush_dec, 0);
    step();

    // Load-use on rs2
    alu1_load = 1; alu1_reg_write = 1; alu1_rd = 5; dec_rs2 = 5;
    #1;
    chk("lu_sf", stall_fetch, 1);
    chk("lu_sd", stall_dec, 1);
    chk("lu_sa", stall_alu1, 0);
    chk("lu_fa", flush_alu1, 1);
    chk("lu_fd", flush_dec, 0);
    step();
    #1 chk("lu_cnt", stall_cnt, 1);
    step();
    // x0 destination and non-writing load never stall
    alu1_load = 1; alu1_reg_write = 1; alu1_rd = 0; dec_rs1 = 0;
    #1 chk("lu_x0", stall_fetch, 0);
    step();
    alu1_load = 1; alu1_reg_write = 0; alu1_rd = 5; dec_rs1 = 5;
    #1 chk("lu_nowr", stall_fetch, 0);
    step();

    // Forwarding priority and fallback
    alu2_rd = 7; alu2_reg_write = 1; wb_rd = 7; wb_reg_write = 1;
    alu1_rs1 = 7; alu1_rs2 = 0;
    #1;
    chk("fwd_alu2", fwd1_sel, 1);
    chk("fwd_rs2_none", fwd2_sel, 0);
    alu2_reg_write = 0;
    #1 chk("fwd_wb", fwd1_sel, 2);
    step();
    alu2_rd = 0; alu2_reg_write = 1; wb_rd = 3; wb_reg_write = 1;
    alu1_rs1 = 0; alu1_rs2 = 3;
    #1;
    chk("fwd_x0", fwd1_sel, 0);
    chk("fwd_rs2_wb", fwd2_sel, 2);
    step();

    // Divide: start cycle 0, done cycle 4
    div_start = 1;
    #1;
    chk("div_c0_sa", stall_alu1, 1);
    chk("div_c0_busy", busy, 0);
    step();
    for (int i = 1; i <= 3; i++) begin
      #1;
      chk("div_wait_sd", stall_dec, 1);
      chk("div_wait_busy", busy, 1);
      step();
    end
    div_done = 1;
    #1;
    chk("div_done_sf", stall_fetch, 0);
    chk("div_done_busy", busy, 1);
    step();
    #1;
    chk("div_after_busy", busy, 0);
    chk("div_after_cnt", stall_cnt, 5);
    step();

    // Single-cycle divide
    div_start = 1; div_done = 1;
    #1 chk("div_1cyc_sf", stall_fetch, 0);
    step();
    #1 chk("div_1cyc_busy", busy, 0);
    step();

    // Redirect, single pulse: flush exactly two cycles
    pc_select = 1;
    #1;
    chk("rd_c0_fd", flush_dec, 1);
    chk("rd_c0_fa", flush_alu1, 1);
    step();
    #1;
    chk("rd_c1_fd", flush_dec, 1);
    chk("rd_c1_busy", busy, 1);
    step();
    #1;
    chk("rd_c2_fd", flush_dec, 0);
    chk("rd_c2_busy", busy, 0);
    step();

    // Second redirect in cycle 1 extends flush to cycle 2
    pc_select = 1;
    step();
    pc_select = 1;
    #1 chk("rd2_c1_fd", flush_dec, 1);
    step();
    #1 chk("rd2_c2_fd", flush_dec, 1);
    step();
    #1 chk("rd2_c3_fd", flush_dec, 0);
    step();

    // Trap during DIV_WAIT: abort once, late done ignored
    div_start = 1;
    step();
    trap = 1;
    #1;
    chk("trap_dw_abort", div_abort, 1);
    chk("trap_dw_fd", flush_dec, 1);
    chk("trap_dw_sf", stall_fetch, 0);
    step();
    div_done = 1;
    #1;
    chk("trap_dw_abort2", div_abort, 0);
    chk("trap_dw_sf2", stall_fetch, 0);
    step();
    div_done = 1;
    #1 chk("trap_dw_late", stall_fetch, 0);
    step();

    // Branch during DIV_WAIT does not abort
    div_start = 1;
    step();
    pc_select = 1;
    #1 chk("pc_dw_abort", div_abort, 0);
    step();
    step();

    // Trap together with div_start in IDLE aborts
    trap = 1; div_start = 1;
    #1;
    chk("trap_start_abort", div_abort, 1);
    chk("trap_start_sf", stall_fetch, 0);
    step();
    step();

    // Reset mid-FLUSH
    pc_select = 1;
    step();
    rst = 1;
    #1 chk("rstf_fd", flush_dec, 0);
    step();
    rst = 0;
    #1;
    chk("rstf_busy", busy, 0);
    chk("rstf_cnt", stall_cnt, 0);
    chk("rstf_fa", flush_alu1, 0);
    step();

    // Reset mid-DIV_WAIT with a coincident trap: no abort
    div_start = 1;
    step();
    rst = 1; trap = 1;
    #1 chk("rstd_abort", div_abort, 0);
    step();
    rst = 0;
    #1 chk("rstd_busy", busy, 0);
    step();

    // Long divide saturates the stall counter
    div_start = 1;
    step();
    repeat (19) step();
    div_done = 1;
    #1 chk("sat_cnt", stall_cnt, CNT_MAX);
    step();
    repeat (3) step();

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
